// File: rtl/pin_test_pattern_gen.sv
// pin_test_pattern_gen: drives N_PINS bring-up test patterns stepped by a programmable prescaler
module pin_test_pattern_gen #(
   parameter int N_PINS = 8,
   parameter int DIV_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [2:0]        mode,
   input  logic [DIV_W-1:0]  div,
   output logic [N_PINS-1:0] pins,
   output logic              tick,
   output logic              wrap
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   function automatic logic [N_PINS-1:0] alt_init();
      logic [N_PINS-1:0] p;
      for (int i = 0; i < N_PINS; i++) p[i] = (i % 2 == 0);
      return p;
   endfunction

   localparam logic [N_PINS-1:0] ALT_INIT = alt_init();

   state_t            r_state, w_state_nxt;
   logic [DIV_W-1:0]  r_cnt, w_cnt_nxt;
   logic [N_PINS-1:0] r_pins, w_pins_nxt, w_init, w_step;
   logic [2:0]        r_mode, w_mode_nxt;
   logic              r_tick, w_tick_nxt, r_wrap, w_wrap_nxt, w_step_wrap;

   // initial pattern uses the live mode (consumed in LOAD); step uses the mode latched at LOAD
   always_comb begin
      w_init      = (mode == 3'd1) ? '1 :
                    (mode == 3'd3) ? N_PINS'(1) :
                    (mode == 3'd5) ? ALT_INIT : '0;
      w_step      = (r_mode == 3'd2 || r_mode == 3'd5) ? ~r_pins :
                    (r_mode == 3'd3) ? {r_pins[N_PINS-2:0], r_pins[N_PINS-1]} :
                    (r_mode == 3'd4) ? r_pins + 1'b1 : r_pins;
      w_step_wrap = (r_mode == 3'd3) ? r_pins[N_PINS-1] :
                    (r_mode == 3'd4) ? &r_pins : 1'b0;
   end

   // next state: enable=0 beats a mode change, which beats a prescaler step
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_pins_nxt  = r_pins;
      w_mode_nxt  = r_mode;
      w_tick_nxt  = 1'b0;
      w_wrap_nxt  = 1'b0;
      case (r_state)
         IDLE: w_state_nxt = enable ? LOAD : IDLE;
         LOAD: begin
            w_pins_nxt  = w_init;
            w_mode_nxt  = mode;
            w_state_nxt = enable ? RUN : IDLE;
         end
         RUN: begin
            if (!enable) w_state_nxt = IDLE;
            else if (mode != r_mode) w_state_nxt = LOAD;
            else if (r_cnt >= div) begin
               w_tick_nxt = 1'b1;
               w_wrap_nxt = w_step_wrap;
               w_pins_nxt = w_step;
            end
            else w_cnt_nxt = r_cnt + 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // state and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_pins  <= '0;
         r_mode  <= '0;
         r_tick  <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pins  <= w_pins_nxt;
         r_mode  <= w_mode_nxt;
         r_tick  <= w_tick_nxt;
         r_wrap  <= w_wrap_nxt;
      end
   end

   assign pins = r_pins;
   assign tick = r_tick;
   assign wrap = r_wrap;
endmodule

// File: tb/tb_pin_test_pattern_gen.sv
// tb_pin_test_pattern_gen: scoreboard bench for pin_test_pattern_gen (N_PINS=4, DIV_W=8)
module tb_pin_test_pattern_gen;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic [2:0] mode = 3'd0;
   logic [7:0] div = 8'd0;
   logic [3:0] pins;
   logic       tick, wrap;
   logic [5:0] exp_q[$];
   logic [5:0] e;
   int         checks = 0;
   int         errors = 0;

   pin_test_pattern_gen #(.N_PINS(4), .DIV_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .div(div),
      .pins(pins), .tick(tick), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      enable = 1'b1;
      mode = 3'd1;
      repeat (3) cyc();
      exp_q.push_back(6'b0);
      e = exp_q.pop_front();
      checks++;
      if ({pins, tick, wrap} !== e) begin
         errors++;
         $display("FAIL reset got=%b exp=%b", {pins, tick, wrap}, e);
      end
   endtask

   task automatic test_all_high();
      do_reset();
      enable = 1'b1; mode = 3'd1; div = 8'd3;
      for (int i = 1; i <= 14; i++) begin
         exp_q.push_back({(i >= 2) ? 4'hF : 4'h0, (i >= 6 && (i - 6) % 4 == 0), 1'b0});
         cyc();
         e = exp_q.pop_front();
         checks++;
         if ({pins, tick, wrap} !== e) begin
            errors++;
            $display("FAIL all_high i=%0d got=%b exp=%b", i, {pins, tick, wrap}, e);
         end
      end
   endtask

   task automatic test_walk();
      logic [3:0] p;
      do_reset();
      enable = 1'b1; mode = 3'd3; div = 8'd0;
      for (int i = 1; i <= 10; i++) begin
         p = (i >= 2) ? 4'(1 << ((i - 2) % 4)) : 4'h0;
         exp_q.push_back({p, i >= 3, i >= 3 && (i - 2) % 4 == 0});
         cyc();
         e = exp_q.pop_front();
         checks++;
         if ({pins, tick, wrap} !== e) begin
            errors++;
            $display("FAIL walk i=%0d got=%b exp=%b", i, {pins, tick, wrap}, e);
         end
      end
   endtask

   task automatic test_count_hold();
      logic [3:0] p;
      do_reset();
      enable = 1'b1; mode = 3'd4; div = 8'd1;
      for (int i = 1; i <= 55; i++) begin
         if (i == 47) enable = 1'b0;
         if (i == 52) enable = 1'b1;
         if (i <= 46) exp_q.push_back({(i < 2) ? 4'h0 : 4'(((i - 2) / 2) % 16), i >= 4 && i % 2 == 0, i == 34});
         else if (i <= 52) exp_q.push_back({4'd6, 2'b00});
         else if (i <= 54) exp_q.push_back(6'b0);
         else exp_q.push_back({4'd1, 2'b10});
         cyc();
         e = exp_q.pop_front();
         checks++;
         if ({pins, tick, wrap} !== e) begin
            errors++;
            $display("FAIL count_hold i=%0d got=%b exp=%b", i, {pins, tick, wrap}, e);
         end
      end
   endtask

   task automatic test_mode_switch();
      logic [5:0] t [14];
      t = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b111110, 6'b111100, 6'b111100,
            6'b010100, 6'b010100, 6'b010100, 6'b101010, 6'b101000, 6'b101000, 6'b010110};
      do_reset();
      enable = 1'b1; mode = 3'd2; div = 8'd2;
      for (int i = 1; i <= 14; i++) begin
         if (i == 7) mode = 3'd5;
         exp_q.push_back(t[i-1]);
         cyc();
         e = exp_q.pop_front();
         checks++;
         if ({pins, tick, wrap} !== e) begin
            errors++;
            $display("FAIL mode_switch i=%0d got=%b exp=%b", i, {pins, tick, wrap}, e);
         end
      end
   endtask

   task automatic test_div_decrease();
      do_reset();
      enable = 1'b1; mode = 3'd1; div = 8'd200;
      for (int i = 1; i <= 176; i++) begin
         if (i == 153) div = 8'd10;
         exp_q.push_back({(i >= 2) ? 4'hF : 4'h0, i == 153 || i == 164 || i == 175, 1'b0});
         cyc();
         e = exp_q.pop_front();
         checks++;
         if ({pins, tick, wrap} !== e) begin
            errors++;
            $display("FAIL div_decrease i=%0d got=%b exp=%b", i, {pins, tick, wrap}, e);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      enable = 1'b1; mode = 3'd3; div = 8'd0;
      repeat (4) cyc();
      #2 rst_n = 1'b0;
      exp_q.push_back(6'b0);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({pins, tick, wrap} !== e) begin
         errors++;
         $display("FAIL async_reset got=%b exp=%b", {pins, tick, wrap}, e);
      end
      @(negedge clk);
      rst_n = 1'b1; mode = 3'd6;
      for (int i = 1; i <= 8; i++) begin
         exp_q.push_back({4'h0, i >= 3, 1'b0});
         cyc();
         e = exp_q.pop_front();
         checks++;
         if ({pins, tick, wrap} !== e) begin
            errors++;
            $display("FAIL reserved_mode i=%0d got=%b exp=%b", i, {pins, tick, wrap}, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_all_high();
      test_walk();
      test_count_hold();
      test_mode_switch();
      test_div_decrease();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
